host_frame_receiver: RTL
========================

# host_frame_receiver

Byte-stream frame assembler that sits directly upstream of the sandbox process. It takes bytes from the host serial receiver and hunts for a sync byte. It assembles a control byte plus a 32-bit little-endian data word, and verifies an XOR checksum. Good frames are presented to the sandbox process through the dataReceived/clearDR handshake; bad or stalled frames are discarded and counted.

## Interface
- SYNC_BYTE, 8'hA5, frame start marker
- TIMEOUT_CYCLES, 100000, max idle cycles between bytes inside a frame (≥2)
- masterClock  in  1  operating clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- rxByteValid  in  1  one-cycle strobe, rxByte valid
- rxByte  in  8  received byte
- clearDR  in  1  from sandbox process; 1 = frame consumed
- dataReceived  out  1  1 = control/inputData hold a verified frame
- control  out  8  frame control byte
- inputData  out  32  frame data word
- frameError  out  1  one-cycle pulse on checksum error or timeout
- errorCount  out  8  saturating count of frameError pulses
- overrun  out  1  sticky; byte arrived while a frame was held

## Operation
- Frame on the wire: SYNC_BYTE, CTRL, D0, D1, D2, D3, CSUM.
- inputData = {D3,D2,D1,D0}.
- CSUM = CTRL^D0^D1^D2^D3.
- States:
  - HUNT: discard bytes until rxByte==SYNC_BYTE, then go to CTRL.
  - CTRL: capture the byte into a shadow control register and a running XOR. Go to DATA with byte index 0.
  - DATA: capture bytes 0..3 into the shadow word at [8i+7:8i] and fold each into the XOR. After index 3, go to CSUM.
  - CSUM: if rxByte==XOR, copy shadow registers to control/inputData, set dataReceived, and go to HOLD. Otherwise pulse frameError and go to HUNT.
  - HOLD: dataReceived=1, outputs frozen. On clearDR=1, clear dataReceived and go to RELEASE.
  - RELEASE: wait for clearDR=0, then go to HUNT.
- A SYNC_BYTE value inside CTRL/DATA/CSUM is treated as data; there is no resync mid-frame.
- Bytes with rxByteValid=1 in HOLD or RELEASE are dropped and set overrun. overrun clears only on reset.
- Timeout: an idle counter runs in CTRL/DATA/CSUM and clears on each accepted byte. After TIMEOUT_CYCLES consecutive cycles without rxByteValid, pulse frameError and go to HUNT.
- errorCount increments on every frameError pulse and saturates at 8'hFF.
- control/inputData change only on a good CSUM. Bad frames never disturb the presented values.

## Timing
- Reset values: dataReceived=0, control=0, inputData=0, frameError=0, errorCount=0, overrun=0, state=HUNT.
- Reset is asynchronous assert. Reset mid-frame or mid-handshake discards everything.
- Latency: dataReceived, control and inputData update on the clock edge that samples the valid CSUM byte. They are visible the following cycle.
- Accept rate: one byte per cycle maximum. Back-to-back strobes are legal.
- Handshake:
  - dataReceived falls on the edge after clearDR is first sampled high.
  - The next frame cannot be presented until clearDR has been sampled low.
  - Earliest next dataReceived rise: 7 accepted bytes after RELEASE exits.
- Simultaneous events:
  - An rxByteValid in the same cycle the idle counter would expire is accepted, and no timeout fires.
  - clearDR=1 while not in HOLD is ignored.
- frameError is high for exactly one cycle per error.
- errorCount updates on the same edge as the frameError pulse.
- In HUNT, HOLD and RELEASE the idle counter is held at 0.

## Test plan
- Good frame: A5 01 11 22 33 44 45 back-to-back → control=8'h01, inputData=32'h44332211, dataReceived=1 the cycle after 45. Then clearDR=1 → dataReceived=0 next cycle.
- Bad checksum: A5 01 11 22 33 44 46 → single frameError pulse, errorCount=1, dataReceived stays 0, control/inputData unchanged.
- Hunt/embedded sync: 00 FF A5 A5 00 00 00 00 A5 → the leading junk is ignored, the second A5 is used as CTRL, and the frame is accepted with control=8'hA5, inputData=0.
- Timeout with TIMEOUT_CYCLES=16: A5 01 11, then 16 idle cycles → frameError pulse and return to HUNT. Then a good frame (A5 01 11 22 33 44 45) is accepted. Repeat the test with a byte arriving on cycle 16 → no error.
- Overrun/handshake: good frame held, hold clearDR=0 and send 3 bytes → overrun=1, outputs unchanged. Raise clearDR and hold it → no new dataReceived until clearDR=0 and a full new frame arrives.
- Reset mid-frame and saturation: assert reset after A5 01 → all outputs at 0, and a subsequent good frame is accepted. Send 260 bad frames → errorCount=8'hFF.

Source files
------------

// File: rtl/host_frame_receiver.sv
// host_frame_receiver: hunts for a sync byte, assembles CTRL + 32-bit LE data word,
// verifies the XOR checksum and presents good frames through dataReceived/clearDR.
// Bad checksums and stalled frames pulse frameError and bump a saturating counter.
module host_frame_receiver #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic        masterClock,
    input  logic        reset,
    input  logic        rxByteValid,
    input  logic [7:0]  rxByte,
    input  logic        clearDR,
    output logic        dataReceived,
    output logic [7:0]  control,
    output logic [31:0] inputData,
    output logic        frameError,
    output logic [7:0]  errorCount,
    output logic        overrun
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        HUNT, CTRL, DATA, CSUM, HOLD, RELEASE
    } state_t;

    state_t             state, stateNext;
    logic [1:0]         byteIdx;
    logic [7:0]         shadowCtrl;
    logic [31:0]        shadowData;
    logic [7:0]         xorAcc;
    logic [IDLE_W-1:0]  idleCnt;

    logic inFrame;
    logic timeout;
    logic errPulse;
    logic present;
    logic dropByte;

    // Idle timer only matters while a frame is being assembled; a byte in the
    // expiring cycle wins over the timeout.
    assign inFrame = (state == CTRL) || (state == DATA) || (state == CSUM);
    assign timeout = inFrame && !rxByteValid && (idleCnt == IDLE_W'(TIMEOUT_CYCLES - 1));

    // State register
    always_ff @(posedge masterClock or negedge reset) begin
        if (!reset) state <= HUNT;
        else        state <= stateNext;
    end

    // Next-state and per-cycle event decode
    always_comb begin
        stateNext = state;
        errPulse  = 1'b0;
        present   = 1'b0;
        dropByte  = 1'b0;
        case (state)
            HUNT: begin
                if (rxByteValid && rxByte == SYNC_BYTE) stateNext = CTRL;
            end
            CTRL: begin
                if (rxByteValid) stateNext = DATA;
                else if (timeout) begin
                    errPulse  = 1'b1;
                    stateNext = HUNT;
                end
            end
            DATA: begin
                if (rxByteValid) begin
                    if (byteIdx == 2'd3) stateNext = CSUM;
                end else if (timeout) begin
                    errPulse  = 1'b1;
                    stateNext = HUNT;
                end
            end
            CSUM: begin
                if (rxByteValid) begin
                    if (rxByte == xorAcc) begin
                        present   = 1'b1;
                        stateNext = HOLD;
                    end else begin
                        errPulse  = 1'b1;
                        stateNext = HUNT;
                    end
                end else if (timeout) begin
                    errPulse  = 1'b1;
                    stateNext = HUNT;
                end
            end
            HOLD: begin
                dropByte = rxByteValid;
                if (clearDR) stateNext = RELEASE;
            end
            RELEASE: begin
                dropByte = rxByteValid;
                if (!clearDR) stateNext = HUNT;
            end
            default: stateNext = HUNT;
        endcase
    end

    // Shadow capture of control byte, data word and running checksum
    always_ff @(posedge masterClock or negedge reset) begin
        if (!reset) begin
            shadowCtrl <= '0;
            shadowData <= '0;
            xorAcc     <= '0;
            byteIdx    <= '0;
        end else if (rxByteValid) begin
            if (state == CTRL) begin
                shadowCtrl <= rxByte;
                xorAcc     <= rxByte;
                byteIdx    <= '0;
            end else if (state == DATA) begin
                shadowData[{byteIdx, 3'b000} +: 8] <= rxByte;
                xorAcc  <= xorAcc ^ rxByte;
                byteIdx <= byteIdx + 2'd1;
            end
        end
    end

    // Idle counter: counts silent cycles inside a frame, zero elsewhere
    always_ff @(posedge masterClock or negedge reset) begin
        if (!reset)                                idleCnt <= '0;
        else if (inFrame && !rxByteValid && !timeout) idleCnt <= idleCnt + IDLE_W'(1);
        else                                       idleCnt <= '0;
    end

    // Presented frame and handshake flag; only a good checksum updates them
    always_ff @(posedge masterClock or negedge reset) begin
        if (!reset) begin
            dataReceived <= 1'b0;
            control      <= '0;
            inputData    <= '0;
        end else if (present) begin
            dataReceived <= 1'b1;
            control      <= shadowCtrl;
            inputData    <= shadowData;
        end else if (state == HOLD && clearDR) begin
            dataReceived <= 1'b0;
        end
    end

    // Error pulse, saturating error count and sticky overrun
    always_ff @(posedge masterClock or negedge reset) begin
        if (!reset) begin
            frameError <= 1'b0;
            errorCount <= '0;
            overrun    <= 1'b0;
        end else begin
            frameError <= errPulse;
            if (errPulse && errorCount != 8'hFF) errorCount <= errorCount + 8'd1;
            if (dropByte) overrun <= 1'b1;
        end
    end

endmodule
